// File: rtl/huff_ser_ctrl_if.sv
// Symbol-stream and serializer-drive bundle for huff_ser_ctrl.
// master = symbol source / cfg writer side, slave = the controller.
interface huff_ser_ctrl_if #(
    parameter int CODE_W = 9,
    parameter int LEN_W  = 4
) ();
    logic              sym_valid;
    logic              sym_ready;
    logic [3:0]        sym;
    logic              sym_last;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic [CODE_W-1:0] cfg_code;
    logic [LEN_W-1:0]  cfg_len;
    logic              trans_start;
    logic [CODE_W-1:0] data;
    logic [LEN_W-1:0]  data_len;

    modport master (
        output sym_valid, sym, sym_last, cfg_we, cfg_addr, cfg_code, cfg_len,
        input  sym_ready, trans_start, data, data_len
    );

    modport slave (
        input  sym_valid, sym, sym_last, cfg_we, cfg_addr, cfg_code, cfg_len,
        output sym_ready, trans_start, data, data_len
    );
endinterface

// File: rtl/huff_ser_ctrl.sv
// Huffman serializer sequencer: symbol -> {code,len} lookup, back-to-back frame drive.
// Define HUFF_SER_BITCNT_EN to add the o_frame_bits per-frame bit counter.
module huff_ser_ctrl #(
    parameter int NSYM   = 10,
    parameter int CODE_W = 9,
    parameter int LEN_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    huff_ser_ctrl_if.slave  bus,
    output logic            o_busy,
    output logic            o_sym_err,
    output logic            o_underrun,
`ifdef HUFF_SER_BITCNT_EN
    output logic            o_cfg_err,
    output logic [15:0]     o_frame_bits
`else
    output logic            o_cfg_err
`endif
);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t            r_state;
    logic [CODE_W-1:0] r_code [NSYM];
    logic [LEN_W-1:0]  r_len  [NSYM];
    logic [CODE_W-1:0] r_data;
    logic [LEN_W-1:0]  r_data_len;
    logic [LEN_W-1:0]  r_bit_cnt;
    logic              r_last;
    logic              r_trans_start;
    logic              r_sym_err;
    logic              r_underrun;
    logic              r_cfg_err;

    logic              w_sym_in;
    logic              w_cfg_in;
    logic [CODE_W-1:0] w_code;
    logic [LEN_W-1:0]  w_len;
    logic              w_legal;
    logic              w_handover;
    logic              w_sym_ready;

    assign w_sym_in   = {1'b0, bus.sym} < 5'(NSYM);
    assign w_cfg_in   = {1'b0, bus.cfg_addr} < 5'(NSYM);
    assign w_handover = (r_state == ST_SEND) && (r_bit_cnt == LEN_W'(1));

    // Lookup reads the registered table, so a same-cycle cfg write sees the old entry.
    always_comb begin
        w_code = '0;
        w_len  = '0;
        if (w_sym_in) begin
            w_code = r_code[bus.sym];
            w_len  = r_len[bus.sym];
        end
    end

    assign w_legal = w_sym_in && (w_len != '0) && (w_len <= LEN_W'(CODE_W));

    always_comb begin
        w_sym_ready = 1'b0;
        case (r_state)
            ST_IDLE: w_sym_ready = 1'b1;
            ST_SEND: w_sym_ready = w_handover && !r_last;
            default: w_sym_ready = 1'b0;
        endcase
    end

`ifdef HUFF_SER_BITCNT_EN
    logic [15:0] r_acc;
    logic [15:0] r_frame_bits;
    logic [16:0] w_acc_sum;
    logic [15:0] w_acc_sat;
    assign w_acc_sum    = {1'b0, r_acc} + 17'(w_len);
    assign w_acc_sat    = w_acc_sum[16] ? 16'hFFFF : w_acc_sum[15:0];
    assign o_frame_bits = r_frame_bits;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_data        <= '0;
            r_data_len    <= '0;
            r_bit_cnt     <= '0;
            r_last        <= 1'b0;
            r_trans_start <= 1'b0;
            r_sym_err     <= 1'b0;
            r_underrun    <= 1'b0;
            r_cfg_err     <= 1'b0;
            for (int i = 0; i < NSYM; i++) begin
                r_code[i] <= '0;
                r_len[i]  <= '0;
            end
`ifdef HUFF_SER_BITCNT_EN
            r_acc        <= '0;
            r_frame_bits <= '0;
`endif
        end else begin
            r_sym_err  <= 1'b0;
            r_underrun <= 1'b0;
            r_cfg_err  <= 1'b0;

            if (bus.cfg_we) begin
                if (r_state == ST_IDLE && w_cfg_in) begin
                    r_code[bus.cfg_addr] <= bus.cfg_code;
                    r_len[bus.cfg_addr]  <= bus.cfg_len;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.sym_valid) begin
                        if (w_legal) begin
                            r_data        <= w_code;
                            r_data_len    <= w_len;
                            r_bit_cnt     <= w_len;
                            r_last        <= bus.sym_last;
                            r_trans_start <= 1'b1;
                            r_state       <= ST_SEND;
`ifdef HUFF_SER_BITCNT_EN
                            r_acc         <= 16'(w_len);
`endif
                        end else begin
                            r_sym_err <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_handover) begin
                        if (!r_last && bus.sym_valid && w_legal) begin
                            // Seamless handover: next code starts the very next cycle.
                            r_data     <= w_code;
                            r_data_len <= w_len;
                            r_bit_cnt  <= w_len;
                            r_last     <= bus.sym_last;
`ifdef HUFF_SER_BITCNT_EN
                            r_acc      <= w_acc_sat;
`endif
                        end else begin
                            r_state       <= ST_IDLE;
                            r_trans_start <= 1'b0;
                            r_bit_cnt     <= '0;
                            if (!r_last) begin
                                r_underrun <= 1'b1;
                                if (bus.sym_valid) r_sym_err <= 1'b1;
                            end
`ifdef HUFF_SER_BITCNT_EN
                            r_frame_bits <= r_acc;
`endif
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - LEN_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sym_ready   = w_sym_ready;
    assign bus.trans_start = r_trans_start;
    assign bus.data        = r_data;
    assign bus.data_len    = r_data_len;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_sym_err       = r_sym_err;
    assign o_underrun      = r_underrun;
    assign o_cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_huff_ser_ctrl.sv
// Directed bench for huff_ser_ctrl: reset, single symbol, back-to-back frame,
// underrun, symbol errors, cfg rules, async reset mid-frame.
module tb_huff_ser_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, sym_err, underrun, cfg_err;
`ifdef HUFF_SER_BITCNT_EN
    logic [15:0] frame_bits;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    huff_ser_ctrl_if #(.CODE_W(9), .LEN_W(4)) bus ();

    huff_ser_ctrl #(.NSYM(10), .CODE_W(9), .LEN_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .o_busy       (busy),
        .o_sym_err    (sym_err),
        .o_underrun   (underrun),
`ifdef HUFF_SER_BITCNT_EN
        .o_cfg_err    (cfg_err),
        .o_frame_bits (frame_bits)
`else
        .o_cfg_err    (cfg_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [3:0] a, input logic [8:0] c, input logic [3:0] l);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_code = c;
        bus.cfg_len  = l;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic send(input logic [3:0] s, input logic last);
        bus.sym_valid = 1'b1;
        bus.sym       = s;
        bus.sym_last  = last;
        tick();
        bus.sym_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.sym_valid = 0; bus.sym = 0; bus.sym_last = 0;
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_code = 0; bus.cfg_len = 0;
        #12;
        checks++;
        if ({bus.trans_start, bus.data, bus.data_len, busy, sym_err, underrun, cfg_err} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got ts=%0b data=%h len=%0d busy=%0b exp all 0",
                     bus.trans_start, bus.data, bus.data_len, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.sym_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %0b exp 1", bus.sym_ready);
        end
    endtask

    task automatic test_single();
        prog(4'd3, 9'b101, 4'd3);
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL t1_cfg_err got %0b exp 0", cfg_err); end
        send(4'd3, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (bus.trans_start !== 1'b1 || bus.data !== 9'h005 || bus.data_len !== 4'd3) begin
                errors++;
                $display("FAIL t1_cycle%0d got ts=%0b data=%h len=%0d exp ts=1 data=005 len=3",
                         c, bus.trans_start, bus.data, bus.data_len);
            end
            tick();
        end
        checks++;
        if (bus.trans_start !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL t1_end got ts=%0b busy=%0b exp 0 0", bus.trans_start, busy);
        end
`ifdef HUFF_SER_BITCNT_EN
        checks++;
        if (frame_bits !== 16'd3) begin errors++; $display("FAIL t1_frame_bits got %0d exp 3", frame_bits); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_d;
        logic [3:0] exp_l;
        logic       exp_r;
        prog(4'd1, 9'b10, 4'd2);
        prog(4'd4, 9'b10011, 4'd5);
        prog(4'd7, 9'h1A5, 4'd9);
        send(4'd1, 1'b0);
        bus.sym_valid = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            if (c <= 2) begin bus.sym = 4'd4; bus.sym_last = 1'b0; end
            else        begin bus.sym = 4'd7; bus.sym_last = 1'b1; end
            if (c <= 2)      begin exp_d = 9'h002; exp_l = 4'd2; end
            else if (c <= 7) begin exp_d = 9'h013; exp_l = 4'd5; end
            else             begin exp_d = 9'h1A5; exp_l = 4'd9; end
            exp_r = (c == 2) || (c == 7);
            #1;
            checks++;
            if (bus.trans_start !== 1'b1 || bus.data !== exp_d || bus.data_len !== exp_l
                || bus.sym_ready !== exp_r) begin
                errors++;
                $display("FAIL t2_cycle%0d got ts=%0b data=%h len=%0d rdy=%0b exp ts=1 data=%h len=%0d rdy=%0b",
                         c, bus.trans_start, bus.data, bus.data_len, bus.sym_ready, exp_d, exp_l, exp_r);
            end
            if (c == 16) bus.sym_valid = 1'b0;
            tick();
        end
        checks++;
        if (bus.trans_start !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL t2_end got ts=%0b busy=%0b underrun=%0b exp 0 0 0", bus.trans_start, busy, underrun);
        end
`ifdef HUFF_SER_BITCNT_EN
        checks++;
        if (frame_bits !== 16'd16) begin errors++; $display("FAIL t2_frame_bits got %0d exp 16", frame_bits); end
`endif
    endtask

    task automatic test_underrun();
        prog(4'd2, 9'b1101, 4'd4);
        send(4'd2, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (bus.trans_start !== 1'b1 || bus.sym_ready !== (c == 4)) begin
                errors++;
                $display("FAIL t3_cycle%0d got ts=%0b rdy=%0b exp ts=1 rdy=%0b",
                         c, bus.trans_start, bus.sym_ready, (c == 4));
            end
            tick();
        end
        checks++;
        if (bus.trans_start !== 1'b0 || underrun !== 1'b1 || sym_err !== 1'b0) begin
            errors++;
            $display("FAIL t3_underrun got ts=%0b underrun=%0b sym_err=%0b exp 0 1 0",
                     bus.trans_start, underrun, sym_err);
        end
        tick();
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL t3_pulse got %0b exp 0", underrun); end
`ifdef HUFF_SER_BITCNT_EN
        checks++;
        if (frame_bits !== 16'd4) begin errors++; $display("FAIL t3_frame_bits got %0d exp 4", frame_bits); end
`endif
    endtask

    task automatic test_sym_err();
        send(4'd12, 1'b1);
        checks++;
        if (sym_err !== 1'b1 || bus.trans_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t4_range got sym_err=%0b ts=%0b busy=%0b exp 1 0 0", sym_err, bus.trans_start, busy);
        end
        tick();
        checks++;
        if (sym_err !== 1'b0) begin errors++; $display("FAIL t4_pulse got %0b exp 0", sym_err); end
        send(4'd5, 1'b1);
        checks++;
        if (sym_err !== 1'b1 || bus.trans_start !== 1'b0) begin
            errors++;
            $display("FAIL t4_unprog got sym_err=%0b ts=%0b exp 1 0", sym_err, bus.trans_start);
        end
        tick();
        // illegal symbol at handover ends the frame as an underrun
        send(4'd2, 1'b0);
        tick(); tick(); tick();
        bus.sym_valid = 1'b1; bus.sym = 4'd12; bus.sym_last = 1'b0;
        #1;
        checks++;
        if (bus.sym_ready !== 1'b1) begin errors++; $display("FAIL t4_hand_rdy got %0b exp 1", bus.sym_ready); end
        tick();
        bus.sym_valid = 1'b0;
        checks++;
        if (sym_err !== 1'b1 || underrun !== 1'b1 || bus.trans_start !== 1'b0) begin
            errors++;
            $display("FAIL t4_hand_bad got sym_err=%0b underrun=%0b ts=%0b exp 1 1 0",
                     sym_err, underrun, bus.trans_start);
        end
        tick();
    endtask

    task automatic test_cfg();
        send(4'd7, 1'b1);
        prog(4'd3, 9'h1FF, 4'd9);
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL t5_busy_write got cfg_err=%0b exp 1", cfg_err); end
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (bus.trans_start !== 1'b0) begin errors++; $display("FAIL t5_frame_end got ts=%0b exp 0", bus.trans_start); end
        send(4'd3, 1'b1);
        checks++;
        if (bus.data !== 9'h005 || bus.data_len !== 4'd3) begin
            errors++; $display("FAIL t5_unchanged got data=%h len=%0d exp 005 3", bus.data, bus.data_len);
        end
        tick(); tick(); tick();
        prog(4'd3, 9'h1FF, 4'd9);
        checks++;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL t5_idle_write got cfg_err=%0b exp 0", cfg_err); end
        prog(4'd12, 9'h0AA, 4'd4);
        checks++;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL t5_bad_addr got cfg_err=%0b exp 1", cfg_err); end
        // write and accept in the same IDLE cycle: old entry is used
        bus.cfg_we = 1'b1; bus.cfg_addr = 4'd3; bus.cfg_code = 9'h00F; bus.cfg_len = 4'd4;
        send(4'd3, 1'b1);
        bus.cfg_we = 1'b0;
        checks++;
        if (bus.data !== 9'h1FF || bus.data_len !== 4'd9 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL t5_same_cycle got data=%h len=%0d cfg_err=%0b exp 1ff 9 0", bus.data, bus.data_len, cfg_err);
        end
        for (int i = 0; i < 9; i++) tick();
        send(4'd3, 1'b1);
        checks++;
        if (bus.data !== 9'h00F || bus.data_len !== 4'd4) begin
            errors++; $display("FAIL t5_new_entry got data=%h len=%0d exp 00f 4", bus.data, bus.data_len);
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset_mid();
        send(4'd7, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.trans_start !== 1'b0 || bus.data !== 9'd0 || bus.data_len !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t6_async got ts=%0b data=%h len=%0d busy=%0b exp 0 0 0 0",
                     bus.trans_start, bus.data, bus.data_len, busy);
        end
`ifdef HUFF_SER_BITCNT_EN
        checks++;
        if (frame_bits !== 16'd0) begin errors++; $display("FAIL t6_frame_bits got %0d exp 0", frame_bits); end
`endif
        tick();
        rst_n = 1'b1;
        tick();
        send(4'd7, 1'b1);
        checks++;
        if (sym_err !== 1'b1 || bus.trans_start !== 1'b0) begin
            errors++;
            $display("FAIL t6_table_cleared got sym_err=%0b ts=%0b exp 1 0", sym_err, bus.trans_start);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_sym_err();
        test_cfg();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
